// File: rtl/sram_resp.sv
// Single-port word SRAM responder with programmable wait states and a stall request to the core.
// Optional feature macro: SRAM_RESP_ERR_EN (out-of-range detection, sticky err, 32'hDEAD_BEEF read data).
module sram_resp #(
    parameter int ADDR_WD     = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        stallreq,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam int         DEPTH     = 2 ** ADDR_WD;

    state_t state;
    state_t next_state;
    logic [3:0] cnt;

    logic [ADDR_WD-1:0] req_idx;
    logic [3:0]         req_we;
    logic [31:0]        req_wdata;
    logic               req_oor;

    logic [31:0] mem [DEPTH];

    logic               accept;
    logic               fire;
    logic [ADDR_WD-1:0] in_idx;
    logic               in_oor;
    logic [ADDR_WD-1:0] acc_idx;
    logic [3:0]         acc_we;
    logic [31:0]        acc_wdata;
    logic               acc_oor;
    logic               unused_addr;

    assign in_idx      = sram_addr[ADDR_WD+1:2];
    assign unused_addr = ^{sram_addr[1:0], sram_addr[31:ADDR_WD+2]};

`ifdef SRAM_RESP_ERR_EN
    assign in_oor = ((sram_addr >> (ADDR_WD + 2)) != 32'd0);
`else
    assign in_oor = 1'b0;
`endif

    // With no wait states the live request is used directly; otherwise the latched copy.
    assign accept    = (state == IDLE) && sram_en;
    assign fire      = NO_WAIT ? accept : ((state == WAIT) && (cnt == 4'd1));
    assign acc_idx   = NO_WAIT ? in_idx     : req_idx;
    assign acc_we    = NO_WAIT ? sram_we    : req_we;
    assign acc_wdata = NO_WAIT ? sram_wdata : req_wdata;
    assign acc_oor   = NO_WAIT ? in_oor     : req_oor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sram_en && !NO_WAIT) next_state = WAIT;
            WAIT:    if (cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stallreq = ((state == IDLE) && sram_en && !NO_WAIT) || (state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept && !NO_WAIT) begin
            cnt <= WAIT_INIT;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_idx   <= in_idx;
            req_we    <= sram_we;
            req_wdata <= sram_wdata;
            req_oor   <= in_oor;
        end
    end

    // Reset suppresses a completing write so an access interrupted by reset leaves memory untouched.
    always_ff @(posedge clk) begin
        if (fire && !reset && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_we[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_rdata <= 32'd0;
        end else if (fire && (acc_we == 4'd0)) begin
            sram_rdata <= acc_oor ? 32'hDEAD_BEEF : mem[acc_idx];
        end
    end

`ifdef SRAM_RESP_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (fire && acc_oor) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
